mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the RV32I subset core. It is the producer side of the ALU control interface.
- Decodes the instruction register contents into per-cycle datapath controls: alucntrl, operand selects, immediate select, register/PC/IR write strobes and memory requests.
- Consumes the ALU EQ flag for branches.
- Sits between the instruction register, memory handshake and datapath muxes.

Parameters:
- WAIT_LIMIT, 255: max cycles a memory state waits for mem_ready before a bus error. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- instr  in  32  instruction register output; valid from DECODE onward
- eq  in  1  ALU equality flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write request (qualifies mem_req)
- adr_src  out  1  memory address: 0 = PC, 1 = ALUResult register
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alucntrl  out  3  000 = add, 001 = sub, 010 = and, 011 = or
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- result_src  out  2  00 = ALUResult register, 01 = read data, 10 = ALU output
- illegal  out  1  unsupported instruction pulse
- bus_err  out  1  sticky timeout flag
- state_dbg  out  4  current state encoding

Behaviour:
- Output style: registered state with combinational Moore outputs. pc_write in FETCH and BRANCH depends on inputs.
- Reset: async rst forces state FETCH, wait counter 0, bus_err 0. While rst is high, all strobes are forced 0: mem_req, mem_we, ir_write, pc_write, reg_write, illegal. state_dbg = 0.
- Default outputs in every state: 0 unless listed below.
- FETCH: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alucntrl = 000, result_src = 10.
  - If mem_ready: ir_write = 1, pc_write = 1, go to DECODE. Otherwise stay.
- DECODE: alu_src_a = 01, alu_src_b = 01, imm_src = 10, alucntrl = 000 (branch target into ALUResult). Next state:
  - opcode 0000011 with f3 = 010 → MEM_ADR
  - opcode 0100011 with f3 = 010 → MEM_ADR
  - opcode 0110011 → EXEC_R
  - opcode 0010011 → EXEC_I
  - opcode 1100011 with f3 = 000 or 001 → BRANCH
  - opcode 1101111 → JAL
  - anything else, or an illegal R/I funct combination: illegal = 1 for this cycle, then FETCH. No write strobes.
- Legal R-type: f7 = 0000000 with f3 ∈ {000, 111, 110}, or f7 = 0100000 with f3 = 000.
- Legal I-type: f3 ∈ {000, 111, 110}.
- MEM_ADR: alu_src_a = 10, alu_src_b = 01, imm_src = 01 for store else 00, alucntrl = 000. Next: load → MEM_RD, store → MEM_WR.
- MEM_RD: mem_req = 1, adr_src = 1. On mem_ready → MEM_WB.
- MEM_WR: mem_req = 1, mem_we = 1, adr_src = 1. On mem_ready → FETCH.
- MEM_WB: reg_write = 1, result_src = 01. Next FETCH.
- EXEC_R: alu_src_a = 10, alu_src_b = 00.
  - alucntrl: add 000, sub 001, and (f3 = 111) 010, or (f3 = 110) 011.
  - Next ALU_WB.
- EXEC_I: alu_src_a = 10, alu_src_b = 01, imm_src = 00.
  - alucntrl: addi 000, andi 010, ori 011.
  - Next ALU_WB.
- ALU_WB: reg_write = 1, result_src = 00. Next FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, alucntrl = 001, result_src = 00.
  - pc_write = (f3 = 000 & eq) | (f3 = 001 & !eq).
  - Next FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, alucntrl = 000, result_src = 00, pc_write = 1. Next ALU_WB (writes oldPC + 4 to rd).
- Timeout:
  - Counter increments each cycle spent in FETCH, MEM_RD or MEM_WR without mem_ready.
  - Counter clears on state change or on mem_ready.
  - If WAIT_LIMIT ≠ 0 and the counter reaches WAIT_LIMIT: bus_err ← 1, go to HALT.
- HALT: all strobes 0. Exit only via rst.
- Latencies: R/I-type 4 cycles, lw 5, sw 4, branch 3, jal 4 (each with zero wait states).

Decomposition:
- Package mc_ctrl_pkg:
  - state_t enum (FETCH = 0, DECODE, MEM_ADR, MEM_RD, MEM_WR, MEM_WB, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, HALT)
  - opcode constants
  - alucntrl constants
  - src/imm/result select encodings
- Sub-module alu_decoder: maps (is_rtype, f3, f7) to alucntrl plus a legal flag. Used by both DECODE (legality check) and EXEC_R/EXEC_I (alucntrl).

Test Plan:
- add 0x002081B3, mem_ready low for 2 cycles:
  - FETCH held 3 cycles, ir_write/pc_write only on the ready cycle.
  - Then DECODE, EXEC_R with alucntrl = 000, ALU_WB with reg_write = 1, result_src = 00, then FETCH.
- sub 0x402081B3 → alucntrl = 001 in EXEC_R. Instr 0x202081B3 (f7 = 0010000) → illegal = 1 in DECODE, next FETCH, no reg_write.
- beq 0x00208463: eq = 1 gives pc_write = 1 in BRANCH, eq = 0 gives 0. bne 0x00209463 gives the inverse.
- lw 0x0000A183, immediate ready:
  - Sequence FETCH, DECODE, MEM_ADR (imm_src = 00), MEM_RD (adr_src = 1), MEM_WB (reg_write = 1, result_src = 01).
  - Total 5 cycles.
- Reset mid-MEM_RD: rst high → all strobes 0 the same cycle. After release, state_dbg = 0 and mem_req = 1 from FETCH.
- WAIT_LIMIT = 4, mem_ready held 0 in FETCH → after 4 cycles bus_err = 1, state HALT, mem_req = 0, held until rst.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// opcodes, funct fields and datapath select values.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEM_ADR = 4'd2,
      MEM_RD  = 4'd3,
      MEM_WR  = 4'd4,
      MEM_WB  = 4'd5,
      EXEC_R  = 4'd6,
      EXEC_I  = 4'd7,
      ALU_WB  = 4'd8,
      BRANCH  = 4'd9,
      JAL     = 4'd10,
      HALT    = 4'd11
   } state_t;

   // opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // funct3 / funct7 values of the supported subset
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   // ALU operations
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   // operand A / operand B selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // immediate formats
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // result mux selects
   localparam logic [1:0] RES_ALUREG = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALUOUT = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Maps R/I-type funct fields to an ALU operation and flags combinations
// outside the supported subset. For I-type, f7 is immediate data and ignored.
module alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic       is_rtype,
   input  logic [2:0] f3,
   input  logic [6:0] f7,
   output logic [2:0] alucntrl,
   output logic       legal
);

   // decode funct fields into an ALU operation and a legality flag
   always_comb begin
      alucntrl = ALU_ADD;
      legal    = 1'b0;
      case (f3)
         F3_ADD: begin
            if (!is_rtype || f7 == F7_BASE) begin
               alucntrl = ALU_ADD;
               legal    = 1'b1;
            end else if (f7 == F7_SUB) begin
               alucntrl = ALU_SUB;
               legal    = 1'b1;
            end
         end
         F3_AND: begin
            if (!is_rtype || f7 == F7_BASE) begin
               alucntrl = ALU_AND;
               legal    = 1'b1;
            end
         end
         F3_OR: begin
            if (!is_rtype || f7 == F7_BASE) begin
               alucntrl = ALU_OR;
               legal    = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the RV32I subset core. Moore outputs from the
// registered state, except pc_write in FETCH and BRANCH which follow inputs.
//
// Memory handshake: mem_req is held high for the whole memory state; a
// transfer completes in the cycle where mem_req and mem_ready are both high,
// and the FSM leaves the memory state on that edge. mem_we qualifies mem_req.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        eq,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alucntrl,
   output logic [1:0]  imm_src,
   output logic [1:0]  result_src,
   output logic        illegal,
   output logic        bus_err,
   output logic [3:0]  state_dbg
);

   localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

   state_t        state, state_next;
   logic [CW-1:0] wait_cnt;
   logic          waiting, timeout;
   logic [6:0]    opcode, f7;
   logic [2:0]    f3, dec_alu;
   logic          is_rtype, dec_legal;
   logic          unused_fields;

   assign opcode        = instr[6:0];
   assign f3            = instr[14:12];
   assign f7            = instr[31:25];
   assign is_rtype      = (opcode == OP_RTYPE);
   assign unused_fields = ^{instr[24:15], instr[11:7]};
   assign state_dbg     = state;

   alu_decoder u_alu_decoder (
      .is_rtype (is_rtype),
      .f3       (f3),
      .f7       (f7),
      .alucntrl (dec_alu),
      .legal    (dec_legal)
   );

   // a memory-facing state is stalled while mem_ready stays low
   assign waiting = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;
   assign timeout = (WAIT_LIMIT != 0) && waiting && ((32'(wait_cnt) + 32'd1) >= WAIT_LIMIT);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_next;
   end

   // stall counter and sticky bus error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         if (waiting && !timeout) wait_cnt <= wait_cnt + CW'(1);
         else                     wait_cnt <= '0;
         if (timeout) bus_err <= 1'b1;
      end
   end

   // next state and datapath controls; strobes are blanked while rst is high
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alucntrl   = ALU_ADD;
      imm_src    = IMM_I;
      result_src = RES_ALUREG;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALUOUT;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (timeout)        state_next = HALT;
            else if (mem_ready) state_next = DECODE;
         end
         DECODE: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_IMM;
            imm_src    = IMM_B;
            illegal    = 1'b1;
            state_next = FETCH;
            case (opcode)
               OP_LOAD, OP_STORE: if (f3 == F3_LW) begin illegal = 1'b0; state_next = MEM_ADR; end
               OP_RTYPE:  if (dec_legal) begin illegal = 1'b0; state_next = EXEC_R; end
               OP_ITYPE:  if (dec_legal) begin illegal = 1'b0; state_next = EXEC_I; end
               OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) begin illegal = 1'b0; state_next = BRANCH; end
               OP_JAL:    begin illegal = 1'b0; state_next = JAL; end
               default: ;
            endcase
         end
         MEM_ADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (timeout)        state_next = HALT;
            else if (mem_ready) state_next = MEM_WB;
         end
         MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (timeout)        state_next = HALT;
            else if (mem_ready) state_next = FETCH;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            result_src = RES_RDATA;
            state_next = FETCH;
         end
         EXEC_R: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alucntrl   = dec_alu;
            state_next = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            imm_src    = IMM_I;
            alucntrl   = dec_alu;
            state_next = ALU_WB;
         end
         ALU_WB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alucntrl   = ALU_SUB;
            pc_write   = ((f3 == F3_BEQ) && eq) || ((f3 == F3_BNE) && !eq);
            state_next = FETCH;
         end
         JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write   = 1'b1;
            state_next = ALU_WB;
         end
         HALT: state_next = HALT;
         default: state_next = FETCH;
      endcase
      if (rst) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
         illegal   = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each scenario queues per-cycle inputs
// with the expected output bundle, then steps the DUT and compares.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        rst, eq, mem_ready;
   logic [31:0] instr;
   logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
   logic [2:0]  alucntrl;
   logic        illegal, bus_err;
   logic [3:0]  state_dbg;

   logic [22:0] obs;
   logic [24:0] exp_q[$];
   logic [24:0] e;
   int          n_cmp = 0;
   int          n_err = 0;

   mc_control_fsm #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alucntrl(alucntrl), .imm_src(imm_src),
      .result_src(result_src), .illegal(illegal), .bus_err(bus_err),
      .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   assign obs = {state_dbg, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, alucntrl, imm_src, result_src, illegal, bus_err};

   // entry = {mem_ready, eq, expected output bundle}
   function automatic logic [24:0] ent(input logic rdy, input logic e_in, input logic [3:0] st,
                                       input logic req, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic [1:0] res, input logic ill, input logic be);
      return {rdy, e_in, st, req, we, adr, irw, pcw, rw, sa, sb, alu, imm, res, ill, be};
   endfunction

   function automatic logic [24:0] x_fetch(input logic r);
      return ent(r, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_decode(input logic il);
      return ent(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 3'b000, 2'b10, 2'b00, il, 1'b0);
   endfunction
   function automatic logic [24:0] x_mem_adr(input logic [1:0] imm);
      return ent(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 3'b000, imm, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_mem_rd(input logic r);
      return ent(r, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_mem_wr(input logic r);
      return ent(r, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_mem_wb();
      return ent(1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_exec_r(input logic [2:0] alu);
      return ent(1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, alu, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_exec_i(input logic [2:0] alu);
      return ent(1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, alu, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_alu_wb();
      return ent(1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_branch(input logic eqv, input logic pcw);
      return ent(1'b0, eqv, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 1'b0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_jal();
      return ent(1'b0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [24:0] x_halt(input logic r);
      return ent(r, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
   endfunction

   // driver: advance to just after the next rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; eq = 1'b0; instr = 32'h0;
      #2;
      n_cmp++;
      if ({state_dbg, mem_req, mem_we, ir_write, pc_write, reg_write, illegal, bus_err} !== 11'd0) begin
         $display("FAIL reset: got state=%0d req=%b we=%b irw=%b pcw=%b rw=%b ill=%b be=%b want all 0",
                  state_dbg, mem_req, mem_we, ir_write, pc_write, reg_write, illegal, bus_err);
         n_err++;
      end
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_add_wait();
      instr = 32'h002081B3;
      exp_q.push_back(x_fetch(1'b0)); exp_q.push_back(x_fetch(1'b0)); exp_q.push_back(x_fetch(1'b1));
      exp_q.push_back(x_decode(1'b0)); exp_q.push_back(x_exec_r(3'b000)); exp_q.push_back(x_alu_wb());
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL add c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         next_cycle();
      end
   endtask

   task automatic test_sub_illegal_r();
      instr = 32'h402081B3;
      exp_q.push_back(x_fetch(1'b1)); exp_q.push_back(x_decode(1'b0));
      exp_q.push_back(x_exec_r(3'b001)); exp_q.push_back(x_alu_wb());
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL sub c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         next_cycle();
      end
      instr = 32'h202081B3;
      exp_q.push_back(x_fetch(1'b1)); exp_q.push_back(x_decode(1'b1)); exp_q.push_back(x_fetch(1'b0));
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL bad_r c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         next_cycle();
      end
   endtask

   task automatic test_itype();
      logic [31:0] ins [3] = '{32'h0FF0F093, 32'h0FF0E093, 32'h00109093};
      logic [2:0]  alu [3] = '{3'b010, 3'b011, 3'b000};
      for (int k = 0; k < 3; k++) begin
         instr = ins[k];
         exp_q.push_back(x_fetch(1'b1));
         if (k < 2) begin
            exp_q.push_back(x_decode(1'b0)); exp_q.push_back(x_exec_i(alu[k])); exp_q.push_back(x_alu_wb());
         end else begin
            exp_q.push_back(x_decode(1'b1));
         end
         for (int c = 0; exp_q.size() > 0; c++) begin
            e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
            if (obs !== e[22:0]) begin $display("FAIL itype%0d c%0d: got %h want %h", k, c, obs, e[22:0]); n_err++; end
            next_cycle();
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins [4] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
      logic        eqv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic        pcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         instr = ins[k];
         exp_q.push_back(x_fetch(1'b1)); exp_q.push_back(x_decode(1'b0)); exp_q.push_back(x_branch(eqv[k], pcw[k]));
         for (int c = 0; exp_q.size() > 0; c++) begin
            e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
            if (obs !== e[22:0]) begin $display("FAIL branch%0d c%0d: got %h want %h", k, c, obs, e[22:0]); n_err++; end
            next_cycle();
         end
      end
   endtask

   task automatic test_jal();
      instr = 32'h008000EF;
      exp_q.push_back(x_fetch(1'b1)); exp_q.push_back(x_decode(1'b0));
      exp_q.push_back(x_jal()); exp_q.push_back(x_alu_wb());
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL jal c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         next_cycle();
      end
   endtask

   task automatic test_load_store();
      instr = 32'h0000A183;
      exp_q.push_back(x_fetch(1'b1)); exp_q.push_back(x_decode(1'b0)); exp_q.push_back(x_mem_adr(2'b00));
      exp_q.push_back(x_mem_rd(1'b1)); exp_q.push_back(x_mem_wb());
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL lw c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         next_cycle();
      end
      instr = 32'h0020A023;
      exp_q.push_back(x_fetch(1'b1)); exp_q.push_back(x_decode(1'b0)); exp_q.push_back(x_mem_adr(2'b01));
      exp_q.push_back(x_mem_wr(1'b0)); exp_q.push_back(x_mem_wr(1'b1)); exp_q.push_back(x_fetch(1'b0));
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL sw c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_read();
      instr = 32'h0000A183;
      exp_q.push_back(x_fetch(1'b1)); exp_q.push_back(x_decode(1'b0));
      exp_q.push_back(x_mem_adr(2'b00)); exp_q.push_back(x_mem_rd(1'b0));
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL rst_mid c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         if (exp_q.size() > 0) next_cycle();
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({state_dbg, mem_req, mem_we, ir_write, pc_write, reg_write, illegal} !== 10'd0) begin
         $display("FAIL rst_mid_strobes: got state=%0d req=%b we=%b irw=%b pcw=%b rw=%b ill=%b want all 0",
                  state_dbg, mem_req, mem_we, ir_write, pc_write, reg_write, illegal);
         n_err++;
      end
      next_cycle();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (obs !== x_fetch(1'b0)) begin $display("FAIL rst_mid_release: got %h want %h", obs, x_fetch(1'b0)); n_err++; end
      next_cycle();
   endtask

   task automatic test_timeout();
      mem_ready = 1'b0;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) exp_q.push_back(x_fetch(1'b0));
      exp_q.push_back(x_halt(1'b0)); exp_q.push_back(x_halt(1'b1)); exp_q.push_back(x_halt(1'b1));
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); mem_ready = e[24]; eq = e[23]; #1; n_cmp++;
         if (obs !== e[22:0]) begin $display("FAIL timeout c%0d: got %h want %h", c, obs, e[22:0]); n_err++; end
         next_cycle();
      end
      rst = 1'b1;
      #1;
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({state_dbg, bus_err, mem_req} !== 6'b0000_0_1) begin
         $display("FAIL timeout_clear: got state=%0d be=%b req=%b want state=0 be=0 req=1", state_dbg, bus_err, mem_req);
         n_err++;
      end
   endtask

   // watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish before 100000");
      $fatal(1, "watchdog");
   end

   // test sequence and final report
   initial begin
      test_reset();
      test_add_wait();
      test_sub_illegal_r();
      test_itype();
      test_branch();
      test_jal();
      test_load_store();
      test_reset_mid_read();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
